// File: rtl/dec_fsm_pkg.sv
// rtl/dec_fsm_pkg.sv - shared state encoding and phase counts for the AES-128 inverse cipher control FSM
package dec_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_PREP,
        INIT_ROUND,
        MID_ROUND,
        LAST_ROUND,
        DONE
    } dec_state_e;

    localparam int MID_PHASES  = 3;
    localparam int LAST_PHASES = 2;
    localparam int PHASE_W     = 2;

endpackage

// File: rtl/decryption_fsm.sv
// rtl/decryption_fsm.sv - AES-128 inverse cipher control FSM: fills the round-key store, then steps the datapath
// Optional feature macro: DEC_KEY_REUSE_EN (skip key preparation when the stored keys are still valid)
module decryption_fsm
    import dec_fsm_pkg::*;
#(
    parameter int NR        = 10,
    parameter int KEY_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 new_key,
    input  logic                 key_exp_valid,
    output logic                 key_exp_req,
    output logic                 key_we,
    output logic [KEY_IDX_W-1:0] key_wr_idx,
    output logic                 key_rd,
    output logic [KEY_IDX_W-1:0] key_rd_idx,
    output logic                 mux_sel,
    output logic                 state_en,
    output logic                 mix_bypass,
    output logic                 busy,
    output logic                 done
);

    dec_state_e           state, state_n;
    logic [KEY_IDX_W-1:0] round, round_n;
    logic [PHASE_W-1:0]   phase, phase_n;
    logic [KEY_IDX_W-1:0] prep_cnt, prep_cnt_n;
    logic                 key_valid, key_valid_n;

`ifndef DEC_KEY_REUSE_EN
    logic unused_new_key;
    assign unused_new_key = new_key;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round     <= KEY_IDX_W'(NR);
            phase     <= '0;
            prep_cnt  <= KEY_IDX_W'(1);
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            round     <= round_n;
            phase     <= phase_n;
            prep_cnt  <= prep_cnt_n;
            key_valid <= key_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        round_n     = round;
        phase_n     = phase;
        prep_cnt_n  = prep_cnt;
        key_valid_n = key_valid;
        key_exp_req = 1'b0;
        key_we      = 1'b0;
        key_wr_idx  = '0;
        key_rd      = 1'b0;
        key_rd_idx  = '0;
        mux_sel     = 1'b0;
        state_en    = 1'b0;
        mix_bypass  = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
`ifdef DEC_KEY_REUSE_EN
                    if (key_valid && !new_key) state_n = INIT_ROUND;
                    else                       state_n = KEY_PREP;
`else
                    state_n = KEY_PREP;
`endif
                end
            end
            KEY_PREP: begin
                // Expander only runs forward, so keys 1..NR land in the store before any round starts
                key_exp_req = 1'b1;
                if (key_exp_valid) begin
                    key_we     = 1'b1;
                    key_wr_idx = prep_cnt;
                    if (prep_cnt == KEY_IDX_W'(NR)) begin
                        state_n     = INIT_ROUND;
                        key_valid_n = 1'b1;
                        prep_cnt_n  = KEY_IDX_W'(1);
                    end else begin
                        prep_cnt_n = prep_cnt + KEY_IDX_W'(1);
                    end
                end
            end
            INIT_ROUND: begin
                key_rd     = 1'b1;
                key_rd_idx = KEY_IDX_W'(NR);
                state_en   = 1'b1;
                state_n    = MID_ROUND;
                round_n    = KEY_IDX_W'(NR - 1);
                phase_n    = PHASE_W'(MID_PHASES - 1);
            end
            MID_ROUND: begin
                mux_sel    = 1'b1;
                key_rd_idx = round;
                key_rd     = (phase == PHASE_W'(1));
                state_en   = (phase == '0);
                if (phase == '0) begin
                    if (round == KEY_IDX_W'(1)) begin
                        state_n = LAST_ROUND;
                        round_n = '0;
                        phase_n = PHASE_W'(LAST_PHASES - 1);
                    end else begin
                        round_n = round - KEY_IDX_W'(1);
                        phase_n = PHASE_W'(MID_PHASES - 1);
                    end
                end else begin
                    phase_n = phase - PHASE_W'(1);
                end
            end
            LAST_ROUND: begin
                mux_sel    = 1'b1;
                mix_bypass = 1'b1;
                key_rd     = (phase == PHASE_W'(1));
                if (phase == '0) begin
                    state_en = 1'b1;
                    state_n  = DONE;
                end else begin
                    phase_n = phase - PHASE_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_decryption_fsm.sv
// tb/tb_decryption_fsm.sv - self-checking bench for decryption_fsm (scoreboarded key traffic, table-driven runs)
module tb_decryption_fsm;

    localparam int NR = 10;
    localparam int W  = 4;

    logic         clk = 1'b0;
    logic         reset, start, new_key, key_exp_valid;
    logic         key_exp_req, key_we, key_rd, mux_sel, state_en, mix_bypass, busy, done;
    logic [W-1:0] key_wr_idx, key_rd_idx;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit mon_on    = 1'b0;

    int         exp_wr_q[$];
    int         exp_rd_q[$];
    logic [1:0] exp_en_q[$];

    typedef struct {
        int   mode;
        logic nk;
        int   lat;
        int   req;
        bit   prep;
    } vec_t;
    vec_t vecs[4];

    decryption_fsm #(.NR(NR), .KEY_IDX_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .new_key(new_key),
        .key_exp_valid(key_exp_valid), .key_exp_req(key_exp_req),
        .key_we(key_we), .key_wr_idx(key_wr_idx), .key_rd(key_rd),
        .key_rd_idx(key_rd_idx), .mux_sel(mux_sel), .state_en(state_en),
        .mix_bypass(mix_bypass), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int outs();
        return int'({key_exp_req, key_we, key_wr_idx, key_rd, key_rd_idx,
                     mux_sel, state_en, mix_bypass, busy, done});
    endfunction

    function automatic void push_exp(input bit prep);
        if (prep) for (int i = 1; i <= NR; i++) exp_wr_q.push_back(i);
        for (int i = NR; i >= 0; i--) exp_rd_q.push_back(i);
        exp_en_q.push_back(2'b00);
        for (int i = 0; i < NR - 1; i++) exp_en_q.push_back(2'b10);
        exp_en_q.push_back(2'b11);
    endfunction

    function automatic void flush();
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_en_q.delete();
    endfunction

    always @(negedge clk) begin
        if (mon_on && !reset) begin
            if (key_we) begin
                check("wr_pending", int'(exp_wr_q.size() > 0), 1);
                if (exp_wr_q.size() > 0) check("wr_idx", int'(key_wr_idx), exp_wr_q.pop_front());
            end
            if (key_rd) begin
                check("rd_pending", int'(exp_rd_q.size() > 0), 1);
                if (exp_rd_q.size() > 0) check("rd_idx", int'(key_rd_idx), exp_rd_q.pop_front());
            end
            if (state_en) begin
                check("en_pending", int'(exp_en_q.size() > 0), 1);
                if (exp_en_q.size() > 0) check("en_mux_bypass", int'({mux_sel, mix_bypass}), int'(exp_en_q.pop_front()));
            end
        end
    end

    task automatic abort_run();
        mon_on = 1'b0;
        start  = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        flush();
    endtask

    task automatic run_case(input int mode, input logic nk, input int exp_lat, input int exp_req,
                            input bit prep, input bit hold, input string tag);
        int cyc = 0;
        int req_cnt = 0;
        int lat = 0;
        push_exp(prep);
        mon_on        = 1'b1;
        new_key       = nk;
        start         = 1'b1;
        key_exp_valid = (mode == 0);
        while (cyc < 200 && lat == 0) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold) start = 1'b0;
            if (done) lat = cyc;
            if (key_exp_req) begin
                key_exp_valid = (mode == 0) || (req_cnt % 2 == 0);
                req_cnt++;
            end else begin
                key_exp_valid = (mode == 0);
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_req_cycles"}, req_cnt, exp_req);
        mon_on = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_idle_after_done"}, int'(busy), 0);
        check({tag, "_writes_left"}, exp_wr_q.size(), 0);
        check({tag, "_reads_left"}, exp_rd_q.size(), 0);
        check({tag, "_loads_left"}, exp_en_q.size(), 0);
        if (hold) begin
            @(posedge clk); #1;
            check({tag, "_rerun_busy"}, int'(busy), 1);
            check({tag, "_rerun_prep"}, int'(key_exp_req), 1);
            abort_run();
        end
        start = 1'b0;
        flush();
    endtask

    initial begin
        bit found;
`ifdef DEC_KEY_REUSE_EN
        vecs[0] = '{0, 1'b0, 41, 10, 1'b1};
        vecs[1] = '{0, 1'b0, 31, 0, 1'b0};
        vecs[2] = '{1, 1'b1, 50, 19, 1'b1};
        vecs[3] = '{1, 1'b0, 31, 0, 1'b0};
`else
        vecs[0] = '{0, 1'b0, 41, 10, 1'b1};
        vecs[1] = '{1, 1'b0, 50, 19, 1'b1};
        vecs[2] = '{0, 1'b1, 41, 10, 1'b1};
        vecs[3] = '{1, 1'b1, 50, 19, 1'b1};
`endif
        reset = 1'b1; start = 1'b0; new_key = 1'b0; key_exp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("outs_in_reset", outs(), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("outs_idle", outs(), 0);

        for (int i = 0; i < 4; i++)
            run_case(vecs[i].mode, vecs[i].nk, vecs[i].lat, vecs[i].req, vecs[i].prep, 1'b0,
                     $sformatf("vec%0d", i));

        run_case(0, 1'b1, 41, 10, 1'b1, 1'b1, "held_start");

        push_exp(1'b1);
        mon_on = 1'b1; new_key = 1'b0; start = 1'b1; key_exp_valid = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (key_rd && key_rd_idx == W'(5)) found = 1'b1;
        end
        check("reach_round5", int'(found), 1);
        mon_on = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        check("outs_after_mid_reset", outs(), 0);
        reset = 1'b0;
        flush();
        run_case(0, 1'b0, 41, 10, 1'b1, 1'b0, "after_reset");

        start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        check("reset_beats_start", int'(busy), 0);
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("start_dropped", int'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
